// File: rtl/mem_lower_pkg.sv
// Shared constants and helpers for the banked register-file memory wrappers.
// Tie-off values are what the ARM two-port RF macros expect in functional mode.
package mem_lower_pkg;

   localparam logic [2:0] EMA      = 3'd3;
   localparam logic [1:0] EMAW     = 2'd0;
   localparam logic       EMAS     = 1'b0;
   localparam logic       COLLDISN = 1'b1;
   localparam logic       RET1N    = 1'b1;
   localparam logic       TEN      = 1'b1;
   localparam logic       TWEN     = 1'b1;
   localparam logic       TCENA    = 1'b0;
   localparam logic       TCENB    = 1'b0;

   localparam int MAX_W = 1024;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Replicate each mask bit gran times; callers cast to their own width.
   function automatic logic [MAX_W-1:0] mask_expand(input logic [MAX_W-1:0] mask, input int gran);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_W; i++) r[i] = mask[i / gran];
      return r;
   endfunction

endpackage

// File: rtl/mem_1r1w_masked_bank.sv
// One macro bank: active-high request to active-low macro pins, tie-offs,
// and a behavioural stand-in for the two-port RF (read port A, write port B).
module mem_1r1w_masked_bank
   import mem_lower_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int MASK_GRAN  = 8,
   parameter int BANK_DEPTH = 32,
   localparam int BW = clog2(BANK_DEPTH),
   localparam int MW = WIDTH / MASK_GRAN
)(
   input  logic             clk,
   input  logic             r_en_i,
   input  logic [BW-1:0]    r_row_i,
   output logic [WIDTH-1:0] r_q_o,
   input  logic             w_en_i,
   input  logic [BW-1:0]    w_row_i,
   input  logic [WIDTH-1:0] w_data_i,
   input  logic [MW-1:0]    w_mask_i
);

   localparam logic FUNC_MODE = (TEN == 1'b1) && (RET1N == 1'b1);

   logic             cena_n;
   logic             cenb_n;
   logic [WIDTH-1:0] wenb_n;

   assign cena_n = ~(r_en_i & FUNC_MODE);
   assign cenb_n = ~(w_en_i & FUNC_MODE);
   assign wenb_n = ~WIDTH'(mask_expand(MAX_W'(w_mask_i), MASK_GRAN));

   // Macro contents are not reset; QA holds until the next enabled read.
   logic [WIDTH-1:0] mem_q [BANK_DEPTH];
   logic [WIDTH-1:0] qa_q;

   always_ff @(posedge clk) begin
      if (!cenb_n) mem_q[w_row_i] <= (mem_q[w_row_i] & wenb_n) | (w_data_i & ~wenb_n);
      if (!cena_n) qa_q <= mem_q[r_row_i];
   end

   assign r_q_o = qa_q;

endmodule

// File: rtl/mem_1r1w_masked_banked.sv
// 1R1W byte-masked memory over NB macro banks: address decode, same-cycle
// read-during-write forwarding, held read data with valid pulse, OOB flags.
module mem_1r1w_masked_banked
   import mem_lower_pkg::*;
#(
   parameter int DEPTH      = 128,
   parameter int WIDTH      = 64,
   parameter int MASK_GRAN  = 8,
   parameter int BANK_DEPTH = 32,
   localparam int AW = clog2(DEPTH),
   localparam int BW = clog2(BANK_DEPTH),
   localparam int NB = (DEPTH + BANK_DEPTH - 1) / BANK_DEPTH,
   localparam int MW = WIDTH / MASK_GRAN,
   localparam int SW = (NB > 1) ? clog2(NB) : 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    R0_addr,
   input  logic             R0_en,
   output logic [WIDTH-1:0] R0_data,
   output logic             R0_valid,
   output logic             R0_oob,
   input  logic [AW-1:0]    W0_addr,
   input  logic             W0_en,
   input  logic [WIDTH-1:0] W0_data,
   input  logic [MW-1:0]    W0_mask,
   output logic             W0_oob
);

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic r_in, w_in, r_acc, w_acc, fwd_hit_d;
   logic [SW-1:0] rd_bank_d;

   assign r_in      = {1'b0, R0_addr} < DEPTH_W;
   assign w_in      = {1'b0, W0_addr} < DEPTH_W;
   assign r_acc     = R0_en & r_in;
   assign w_acc     = W0_en & w_in;
   assign fwd_hit_d = r_acc & w_acc & (R0_addr == W0_addr);
   assign rd_bank_d = SW'(R0_addr >> BW);

   logic [NB-1:0]            bank_rsel, bank_wsel;
   logic [NB-1:0][WIDTH-1:0] bank_q;

   for (genvar b = 0; b < NB; b++) begin : g_bank
      assign bank_rsel[b] = r_acc && ((R0_addr >> BW) == AW'(b));
      assign bank_wsel[b] = w_acc && ((W0_addr >> BW) == AW'(b));

      mem_1r1w_masked_bank #(
         .WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN), .BANK_DEPTH(BANK_DEPTH)
      ) u_bank (
         .clk      (clk),
         .r_en_i   (bank_rsel[b]),
         .r_row_i  (R0_addr[BW-1:0]),
         .r_q_o    (bank_q[b]),
         .w_en_i   (bank_wsel[b]),
         .w_row_i  (W0_addr[BW-1:0]),
         .w_data_i (W0_data),
         .w_mask_i (W0_mask)
      );
   end

   logic [SW-1:0]    rd_bank_q;
   logic             rd_zero_q, fwd_hit_q, have_data_q;
   logic [WIDTH-1:0] fwd_data_q;
   logic [MW-1:0]    fwd_mask_q;
   logic             r_valid_q, r_oob_q, w_oob_q;

   // Read-side state only moves on a read (accepted or OOB) so R0_data holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_bank_q   <= '0;
         rd_zero_q   <= 1'b0;
         fwd_hit_q   <= 1'b0;
         fwd_data_q  <= '0;
         fwd_mask_q  <= '0;
         have_data_q <= 1'b0;
         r_valid_q   <= 1'b0;
         r_oob_q     <= 1'b0;
         w_oob_q     <= 1'b0;
      end else begin
         r_valid_q <= R0_en;
         r_oob_q   <= R0_en & ~r_in;
         w_oob_q   <= W0_en & ~w_in;
         if (R0_en) begin
            rd_bank_q   <= rd_bank_d;
            rd_zero_q   <= ~r_in;
            fwd_hit_q   <= fwd_hit_d;
            fwd_data_q  <= W0_data;
            fwd_mask_q  <= W0_mask;
            have_data_q <= 1'b1;
         end
      end
   end

   logic [WIDTH-1:0] q_sel, fwd_bits;

   always_comb begin
      q_sel = '0;
      for (int b = 0; b < NB; b++)
         if (rd_bank_q == SW'(b)) q_sel = bank_q[b];
      fwd_bits = fwd_hit_q ? WIDTH'(mask_expand(MAX_W'(fwd_mask_q), MASK_GRAN)) : '0;
      R0_data  = '0;
      if (have_data_q && !rd_zero_q) R0_data = (fwd_data_q & fwd_bits) | (q_sel & ~fwd_bits);
   end

   assign R0_valid = r_valid_q;
   assign R0_oob   = r_oob_q;
   assign W0_oob   = w_oob_q;

endmodule

// File: tb/tb_mem_1r1w_masked_banked.sv
// Randomised and directed bench for mem_1r1w_masked_banked (partial last bank).
module tb_mem_1r1w_masked_banked;

   localparam int DEPTH = 100;
   localparam int WIDTH = 64;
   localparam int MG    = 8;
   localparam int BD    = 32;
   localparam int AW    = 7;
   localparam int MW    = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0]    R0_addr = '0, W0_addr = '0;
   logic             R0_en = 1'b0, W0_en = 1'b0;
   logic [WIDTH-1:0] W0_data = '0;
   logic [MW-1:0]    W0_mask = '0;
   logic [WIDTH-1:0] R0_data;
   logic             R0_valid, R0_oob, W0_oob;

   mem_1r1w_masked_banked #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(MG), .BANK_DEPTH(BD)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
      .R0_valid(R0_valid), .R0_oob(R0_oob),
      .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
      .W0_mask(W0_mask), .W0_oob(W0_oob)
   );

   // Reference: word array updated lane by lane; a read sees this cycle's write.
   logic [WIDTH-1:0] ref_mem [128];
   logic [WIDTH-1:0] exp_data = '0;
   bit               exp_valid, exp_roob, exp_woob;
   logic [3:0]       wsel_seen;
   int               checks = 0, errors = 0;

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic step(input bit re, input int ra, input bit we, input int wa,
                       input logic [63:0] wd, input logic [7:0] wm);
      @(negedge clk);
      R0_en = re; R0_addr = ra[6:0];
      W0_en = we; W0_addr = wa[6:0]; W0_data = wd; W0_mask = wm;
      if (we && wa < DEPTH)
         for (int l = 0; l < MW; l++)
            if (wm[l]) ref_mem[wa][l*MG +: MG] = wd[l*MG +: MG];
      exp_valid = re;
      exp_roob  = re && (ra >= DEPTH);
      exp_woob  = we && (wa >= DEPTH);
      if (re) exp_data = (ra < DEPTH) ? ref_mem[ra] : 64'd0;
      #1 wsel_seen = u_dut.bank_wsel;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (R0_data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", R0_data); end
      if (R0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", R0_valid); end
      if (R0_oob !== 1'b0)   begin errors++; $display("FAIL reset_roob got=%b exp=0", R0_oob); end
      if (W0_oob !== 1'b0)   begin errors++; $display("FAIL reset_woob got=%b exp=0", W0_oob); end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, 64'd0, 8'h00);
         checks += 2;
         if (R0_data !== 64'd0) begin errors++; $display("FAIL idle_data cyc=%0d got=%h exp=0", i, R0_data); end
         if (R0_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, R0_valid); end
      end
   endtask

   task automatic test_fill();
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0, 1, a, rnd64(), 8'hFF);
         checks++;
         if (W0_oob !== 1'b0) begin errors++; $display("FAIL fill_woob addr=%0d got=%b exp=0", a, W0_oob); end
      end
   endtask

   task automatic test_bank_cross();
      step(0, 0, 1, 31, {16{4'h1}}, 8'hFF);
      step(0, 0, 1, 32, {16{4'h2}}, 8'hFF);
      step(1, 31, 0, 0, 64'd0, 8'h00);
      checks += 2;
      if (R0_data !== {16{4'h1}}) begin errors++; $display("FAIL bank_cross_31 got=%h exp=%h", R0_data, {16{4'h1}}); end
      if (R0_valid !== 1'b1) begin errors++; $display("FAIL bank_cross_v31 got=%b exp=1", R0_valid); end
      step(1, 32, 0, 0, 64'd0, 8'h00);
      checks += 2;
      if (R0_data !== {16{4'h2}}) begin errors++; $display("FAIL bank_cross_32 got=%h exp=%h", R0_data, {16{4'h2}}); end
      if (R0_valid !== 1'b1) begin errors++; $display("FAIL bank_cross_v32 got=%b exp=1", R0_valid); end
   endtask

   task automatic test_masked();
      step(0, 0, 1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      step(0, 0, 1, 5, 64'd0, 8'h0F);
      step(1, 5, 0, 0, 64'd0, 8'h00);
      checks++;
      if (R0_data !== 64'hFFFF_FFFF_0000_0000) begin
         errors++; $display("FAIL masked_write got=%h exp=ffffffff00000000", R0_data);
      end
   endtask

   task automatic test_collision();
      step(0, 0, 1, 7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      step(1, 7, 1, 7, 64'h5555_5555_5555_5555, 8'hF0);
      checks += 2;
      if (R0_data !== 64'h5555_5555_AAAA_AAAA) begin errors++; $display("FAIL collision got=%h exp=55555555aaaaaaaa", R0_data); end
      if (R0_valid !== 1'b1) begin errors++; $display("FAIL collision_valid got=%b exp=1", R0_valid); end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 64'd0, 8'h00);
         checks += 2;
         if (R0_data !== 64'h5555_5555_AAAA_AAAA) begin errors++; $display("FAIL collision_hold cyc=%0d got=%h", i, R0_data); end
         if (R0_valid !== 1'b0) begin errors++; $display("FAIL collision_hold_valid cyc=%0d got=%b exp=0", i, R0_valid); end
      end
   endtask

   task automatic test_oob();
      step(0, 0, 1, 110, rnd64(), 8'hFF);
      checks += 2;
      if (W0_oob !== 1'b1)   begin errors++; $display("FAIL oob_wflag got=%b exp=1", W0_oob); end
      if (wsel_seen !== 4'd0) begin errors++; $display("FAIL oob_wsel got=%b exp=0000", wsel_seen); end
      step(1, 110, 0, 0, 64'd0, 8'h00);
      checks += 4;
      if (R0_oob !== 1'b1)   begin errors++; $display("FAIL oob_rflag got=%b exp=1", R0_oob); end
      if (R0_valid !== 1'b1) begin errors++; $display("FAIL oob_rvalid got=%b exp=1", R0_valid); end
      if (R0_data !== 64'd0) begin errors++; $display("FAIL oob_rdata got=%h exp=0", R0_data); end
      if (W0_oob !== 1'b0)   begin errors++; $display("FAIL oob_wflag_clear got=%b exp=0", W0_oob); end
      step(1, 99, 0, 0, 64'd0, 8'h00);
      checks += 2;
      if (R0_data !== exp_data) begin errors++; $display("FAIL last_row got=%h exp=%h", R0_data, exp_data); end
      if (R0_oob !== 1'b0)      begin errors++; $display("FAIL last_row_oob got=%b exp=0", R0_oob); end
   endtask

   task automatic test_zero_mask();
      step(1, 40, 1, 40, rnd64(), 8'h00);
      checks++;
      if (R0_data !== exp_data) begin errors++; $display("FAIL zero_mask_fwd got=%h exp=%h", R0_data, exp_data); end
      step(1, 40, 0, 0, 64'd0, 8'h00);
      checks++;
      if (R0_data !== exp_data) begin errors++; $display("FAIL zero_mask_read got=%h exp=%h", R0_data, exp_data); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int ra, wa;
         ra = $urandom_range(0, 127);
         wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 127);
         step($urandom_range(0, 1) == 1, ra, $urandom_range(0, 1) == 1, wa, rnd64(), 8'($urandom()));
         checks += 4;
         if (R0_data !== exp_data)   begin errors++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, R0_data, exp_data); end
         if (R0_valid !== exp_valid) begin errors++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, R0_valid, exp_valid); end
         if (R0_oob !== exp_roob)    begin errors++; $display("FAIL rand_roob i=%0d got=%b exp=%b", i, R0_oob, exp_roob); end
         if (W0_oob !== exp_woob)    begin errors++; $display("FAIL rand_woob i=%0d got=%b exp=%b", i, W0_oob, exp_woob); end
      end
   endtask

   task automatic test_reset_during_read();
      @(negedge clk);
      R0_en = 1'b1; R0_addr = 7'd3; W0_en = 1'b0;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      checks += 2;
      if (R0_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got=%b exp=0", R0_valid); end
      if (R0_data !== 64'd0) begin errors++; $display("FAIL rst_rd_data got=%h exp=0", R0_data); end
      @(negedge clk) R0_en = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      exp_data = '0;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 64'd0, 8'h00);
         checks += 2;
         if (R0_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid cyc=%0d got=%b exp=0", i, R0_valid); end
         if (R0_data !== 64'd0) begin errors++; $display("FAIL post_rst_data cyc=%0d got=%h exp=0", i, R0_data); end
      end
      step(0, 0, 1, 20, rnd64(), 8'hFF);
      step(1, 20, 0, 0, 64'd0, 8'h00);
      checks += 2;
      if (R0_data !== exp_data) begin errors++; $display("FAIL post_rst_read got=%h exp=%h", R0_data, exp_data); end
      if (R0_valid !== 1'b1)    begin errors++; $display("FAIL post_rst_read_valid got=%b exp=1", R0_valid); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_bank_cross();
      test_masked();
      test_collision();
      test_oob();
      test_zero_mask();
      test_random();
      test_reset_during_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
